// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command scheduler: FSM state encoding,
// default interface widths and transaction timing.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP,
        ST_GAP
    } sched_state_t;

    localparam int LENGTH_SEND_DEF   = 16;
    localparam int LENGTH_RECV_DEF   = 16;
    localparam int PERIPH_SEL_DEF    = 2;
    localparam int FIFO_DEPTH_DEF    = 4;
    localparam int XFER_CYCLES_DEF   = 44;
    localparam int GAP_CYCLES_DEF    = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command queue; DEPTH must be a power of two so the pointers
// wrap naturally. Pushes are refused while full regardless of a same-cycle pop.
module spi_cmd_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries behind a valid write are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Queues SPI commands and sequences them one at a time through an external
// SPI controller: launch, fixed-length wait, capture, handshake, idle gap.
module spi_cmd_scheduler
    import spi_pkg::*;
#(
    parameter int LENGTH_SEND_C     = LENGTH_SEND_DEF,
    parameter int LENGTH_RECIEVED_C = LENGTH_RECV_DEF,
    parameter int PERIPHERY_SELECT  = PERIPH_SEL_DEF,
    parameter int FIFO_DEPTH        = FIFO_DEPTH_DEF,
    parameter int XFER_CYCLES       = XFER_CYCLES_DEF,
    parameter int GAP_CYCLES        = GAP_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [LENGTH_SEND_C-1:0]     cmd_data,
    input  logic [PERIPHERY_SELECT-1:0]  cmd_cs,
    output logic                         start_comm,
    output logic [LENGTH_SEND_C-1:0]     data_send_c,
    output logic [PERIPHERY_SELECT-1:0]  CS_in,
    input  logic [LENGTH_RECIEVED_C-1:0] CIPO_register,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [LENGTH_RECIEVED_C-1:0] rsp_data,
    output logic [PERIPHERY_SELECT-1:0]  rsp_cs,
    output logic                         busy
);

    localparam int ENTRY_W = PERIPHERY_SELECT + LENGTH_SEND_C;
    localparam int CNT_W   = $clog2(max_int(XFER_CYCLES, GAP_CYCLES) + 1);
    // WAIT lasts XFER_CYCLES-1 cycles so LAUNCH+WAIT spans XFER_CYCLES; needs XFER_CYCLES >= 2.
    localparam logic [CNT_W-1:0] XFER_TC = CNT_W'(XFER_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] fifo_head;
    logic               load_cmd;
    logic               capture_rsp;

    assign cmd_ready = !fifo_full;

    spi_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_cs, cmd_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        fifo_pop    = 1'b0;
        load_cmd    = 1'b0;
        capture_rsp = 1'b0;
        start_comm  = 1'b0;
        rsp_valid   = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_LAUNCH;
                    load_cmd   = 1'b1;
                end
            end
            ST_LAUNCH: begin
                start_comm = 1'b1;
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == XFER_TC) begin
                    cnt_next   = '0;
                    state_next = ST_CAPTURE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                capture_rsp = 1'b1;
                fifo_pop    = 1'b1;
                state_next  = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    cnt_next   = '0;
                    state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_TC) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The command word is latched on the way into LAUNCH, so queue traffic during
    // the transfer cannot disturb what the controller is shifting out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_send_c <= '0;
            CS_in       <= '0;
            rsp_data    <= '0;
            rsp_cs      <= '0;
        end else begin
            if (load_cmd) begin
                {CS_in, data_send_c} <= fifo_head;
            end
            if (capture_rsp) begin
                rsp_data <= CIPO_register;
                rsp_cs   <= fifo_head[ENTRY_W-1 -: PERIPHERY_SELECT];
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Scoreboard bench for spi_cmd_scheduler; a peripheral model answers each
// launch with the nibble-reversed transmit word.
module tb_spi_cmd_scheduler;

    localparam int XC  = 44;
    localparam int GC  = 4;
    localparam int LAT = XC + 1;                       // launch cycle to rsp_valid rise
    localparam int LL  = 1 + (XC - 1) + 1 + 1 + GC + 1; // launch to launch, rsp_ready high

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_cs;
    logic        start_comm;
    logic [15:0] data_send_c;
    logic [1:0]  CS_in;
    logic [15:0] CIPO_register;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_cs;
    logic        busy;

    spi_cmd_scheduler #(
        .LENGTH_SEND_C     (16),
        .LENGTH_RECIEVED_C (16),
        .PERIPHERY_SELECT  (2),
        .FIFO_DEPTH        (4),
        .XFER_CYCLES       (XC),
        .GAP_CYCLES        (GC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .cmd_cs        (cmd_cs),
        .start_comm    (start_comm),
        .data_send_c   (data_send_c),
        .CS_in         (CS_in),
        .CIPO_register (CIPO_register),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_cs        (rsp_cs),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] nibrev(input logic [15:0] d);
        return {d[3:0], d[7:4], d[11:8], d[15:12]};
    endfunction

    logic [17:0] exp_launch [$];
    logic [17:0] exp_rsp [$];
    logic [17:0] e;
    int          n_launch = 0;
    int          n_rsp = 0;
    int          last_launch_cyc = 0;
    int          last_ll = 0;
    logic        prev_rv = 1'b0;
    logic [15:0] last_rsp_data = '0;
    logic [1:0]  last_rsp_cs = '0;

    // Monitor, scoreboard and peripheral model, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_rv = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                exp_launch.push_back({cmd_cs, cmd_data});
                exp_rsp.push_back({cmd_cs, nibrev(cmd_data)});
            end
            if (start_comm) begin
                if (n_launch > 0) last_ll = cyc - last_launch_cyc;
                n_launch++;
                last_launch_cyc = cyc;
                if (exp_launch.size() == 0) begin
                    check("launch_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_launch.pop_front();
                    check("launch_cs", 32'(CS_in), 32'(e[17:16]));
                    check("launch_data", 32'(data_send_c), 32'(e[15:0]));
                end
                CIPO_register = nibrev(data_send_c);
            end
            if (rsp_valid && !prev_rv)
                check("rsp_latency", 32'(cyc - last_launch_cyc), 32'(LAT));
            prev_rv = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                last_rsp_data = rsp_data;
                last_rsp_cs   = rsp_cs;
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_cs", 32'(rsp_cs), 32'(e[17:16]));
                    check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
                end
            end
        end
    end

    task automatic send(input logic [1:0] cs, input logic [15:0] d, output int acc_cyc);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        acc_cyc = 0;
        cmd_valid = 1'b1;
        cmd_cs = cs;
        cmd_data = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = cmd_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rsp(input int target, input int bound);
        int n;
        n = 0;
        while (n_rsp < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (n_rsp < target) check("rsp_timeout", 32'(n_rsp), 32'(target));
    endtask

    task automatic wait_launch(input int base);
        int n;
        n = 0;
        while (n_launch <= base && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n_launch <= base) check("launch_timeout", 32'(n_launch), 32'(base + 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          acc_cyc;
    int          first_l;
    int          base_l;
    int          base_r;
    int          bad;
    int          n;
    logic [15:0] hold_d;
    logic [1:0]  hold_cs;
    int          hold_l;
    logic        acc;

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        cmd_cs = '0;
        rsp_ready = 1'b1;
        CIPO_register = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_comm", 32'(start_comm), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_send_c", 32'(data_send_c), 32'd0);
        check("rst_cs_in", 32'(CS_in), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_cs", 32'(rsp_cs), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Single command
        base_l = n_launch;
        base_r = n_rsp;
        send(2'd2, 16'hA5C3, acc_cyc);
        wait_rsp(base_r + 1, 200);
        check("single_launch_count", 32'(n_launch - base_l), 32'd1);
        check("single_rsp_data", 32'(last_rsp_data), 32'h3C5A);
        check("single_rsp_cs", 32'(last_rsp_cs), 32'd2);
        check("single_cs_in", 32'(CS_in), 32'd2);
        check("single_data_send", 32'(data_send_c), 32'hA5C3);
        wait_idle();

        // Five back-to-back commands against a four-deep queue
        base_l = n_launch;
        base_r = n_rsp;
        for (int i = 0; i < 4; i++)
            send(2'(i), 16'(16'h1111 * (i + 1)), acc_cyc);
        check("full_after_4", 32'(cmd_ready), 32'd0);
        check("burst_first_launch", 32'(n_launch - base_l), 32'd1);
        first_l = last_launch_cyc;
        send(2'd3, 16'hC0DE, acc_cyc);
        check("fifth_after_capture", 32'(acc_cyc - first_l), 32'(XC + 1));
        wait_rsp(base_r + 5, 600);
        check("burst_launch_gap", 32'(last_ll), 32'(LL));
        check("burst_sb_empty", 32'(exp_rsp.size()), 32'd0);
        wait_idle();

        // Response back-pressure
        base_r = n_rsp;
        rsp_ready = 1'b0;
        send(2'd1, 16'h0F0F, acc_cyc);
        send(2'd3, 16'hBEEF, acc_cyc);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_seen", 32'(rsp_valid), 32'd1);
        hold_d = rsp_data;
        hold_cs = rsp_cs;
        hold_l = n_launch;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== hold_d || rsp_cs !== hold_cs) bad++;
        end
        check("stall_stable", 32'(bad), 32'd0);
        check("stall_no_launch", 32'(n_launch), 32'(hold_l));
        check("stall_no_rsp", 32'(n_rsp), 32'(base_r));
        check("stall_data", 32'(hold_d), 32'(nibrev(16'h0F0F)));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_rsp(base_r + 2, 300);
        wait_idle();

        // Queue-side activity while a transfer is in WAIT
        base_l = n_launch;
        base_r = n_rsp;
        send(2'd2, 16'h5A5A, acc_cyc);
        wait_launch(base_l);
        bad = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            cmd_data = 16'($urandom);
            cmd_cs = 2'($urandom);
            @(negedge clk);
            if (data_send_c !== 16'h5A5A || CS_in !== 2'd2) bad++;
        end
        check("wait_outputs_stable", 32'(bad), 32'd0);
        wait_rsp(base_r + 1, 200);
        wait_idle();

        // Reset in the middle of WAIT with three commands queued
        base_l = n_launch;
        send(2'd1, 16'h1234, acc_cyc);
        send(2'd2, 16'h2345, acc_cyc);
        send(2'd3, 16'h3456, acc_cyc);
        wait_launch(base_l);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_launch.delete();
        exp_rsp.delete();
        #1;
        check("mid_rst_start_comm", 32'(start_comm), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_data_send_c", 32'(data_send_c), 32'd0);
        check("mid_rst_cs_in", 32'(CS_in), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        check("mid_rst_rsp_cs", 32'(rsp_cs), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        hold_l = n_launch;
        base_r = n_rsp;
        repeat (100) @(posedge clk);
        #1;
        check("post_rst_no_launch", 32'(n_launch), 32'(hold_l));
        check("post_rst_no_rsp", 32'(n_rsp), 32'(base_r));
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Push on the CAPTURE cycle with three commands queued
        base_l = n_launch;
        base_r = n_rsp;
        send(2'd0, 16'h1111, acc_cyc);
        send(2'd1, 16'h2222, acc_cyc);
        send(2'd2, 16'h3333, acc_cyc);
        wait_launch(base_l);
        n = 0;
        @(posedge clk);
        #1;
        while (cyc != last_launch_cyc + XC && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b1;
        cmd_cs = 2'd3;
        cmd_data = 16'h4444;
        @(negedge clk);
        acc = cmd_ready;
        check("cap_push_ready", 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("cap_occ_not_full", 32'(cmd_ready), 32'd1);
        send(2'd0, 16'h5555, acc_cyc);
        check("cap_occ_full", 32'(cmd_ready), 32'd0);
        wait_rsp(base_r + 5, 1000);
        check("cap_launch_count", 32'(n_launch - base_l), 32'd5);
        check("cap_sb_empty", 32'(exp_rsp.size()), 32'd0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
